// File: rtl/gmii_tx_framer_pkg.sv
// gmii_tx_framer_pkg: GMII framing bytes, CRC-32 constants and framer state encodings.
package gmii_tx_framer_pkg;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_POLY_REF = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN = 3'd1;
  localparam logic [2:0] ST_PRE = 3'd2;
  localparam logic [2:0] ST_SFD = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;
  localparam logic [2:0] ST_PAD = 3'd5;
  localparam logic [2:0] ST_FCS = 3'd6;
  localparam logic [2:0] ST_IFG = 3'd7;
endpackage

// File: rtl/gmii_tx_framer_crc32_d8.sv
// crc32_d8: one-byte step of the reflected IEEE 802.3 CRC-32, shared with the receive checker.
module crc32_d8
  import gmii_tx_framer_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  d,
  output logic [31:0] crc_next
);
  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++)
      crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ d[i]) ? CRC_POLY_REF : 32'h0);
  end
endmodule

// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: drains length/data FIFOs and emits GMII frames with preamble, pad, FCS and IFG.
module gmii_tx_framer
  import gmii_tx_framer_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME = 60,
  parameter int IFG_BYTES = 12,
  parameter int LEN_W = 12
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        ptr_fifo_rd,
  input  logic [15:0] ptr_fifo_dout,
  input  logic        ptr_fifo_empty,
  output logic        data_fifo_rd,
  input  logic [7:0]  data_fifo_dout,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        tx_busy,
  output logic        frame_sent,
  output logic        len_err
);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_FRAME);
  logic [2:0] state;
  logic [LEN_W-1:0] n_q, cnt;
  logic [31:0] crc_q, crc_n;
  logic armed, last_data, pad_needed;
  logic [15-LEN_W:0] len_unused;
  assign len_unused = ptr_fifo_dout[15:LEN_W];
  assign last_data = cnt == n_q - 1'b1;
  assign pad_needed = n_q < MIN_L;
  // armed keeps the length strobe quiet on the first cycle after reset release
  assign ptr_fifo_rd = armed && state == ST_IDLE && !ptr_fifo_empty;
  assign data_fifo_rd = state == ST_SFD || (state == ST_DATA && !last_data);
  assign len_err = state == ST_LEN && ptr_fifo_dout[LEN_W-1:0] == '0;
  assign tx_busy = ptr_fifo_rd || state != ST_IDLE;
  assign gmii_tx_er = 1'b0;
  crc32_d8 u_crc (
    .crc(crc_q),
    .d(state == ST_DATA ? data_fifo_dout : 8'h00),
    .crc_next(crc_n)
  );
  // the output register lags the state by one cycle, so LEN already loads the first preamble byte
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      n_q <= '0;
      cnt <= '0;
      crc_q <= CRC_INIT;
      armed <= 1'b0;
      gmii_txd <= 8'h00;
      gmii_tx_en <= 1'b0;
      frame_sent <= 1'b0;
    end else begin
      armed <= 1'b1;
      frame_sent <= state == ST_FCS && cnt[1:0] == 2'd3;
      case (state)
        ST_IDLE: begin
          gmii_txd <= 8'h00;
          gmii_tx_en <= 1'b0;
          state <= ptr_fifo_rd ? ST_LEN : ST_IDLE;
        end
        ST_LEN: begin
          n_q <= ptr_fifo_dout[LEN_W-1:0];
          cnt <= '0;
          gmii_txd <= len_err ? 8'h00 : PREAMBLE_BYTE;
          gmii_tx_en <= !len_err;
          state <= len_err ? ST_IFG : (PREAMBLE_LEN > 1 ? ST_PRE : ST_SFD);
        end
        ST_PRE: begin
          gmii_txd <= PREAMBLE_BYTE;
          cnt <= cnt == LEN_W'(PREAMBLE_LEN - 2) ? '0 : cnt + 1'b1;
          state <= cnt == LEN_W'(PREAMBLE_LEN - 2) ? ST_SFD : ST_PRE;
        end
        ST_SFD: begin
          gmii_txd <= SFD_BYTE;
          cnt <= '0;
          state <= ST_DATA;
        end
        ST_DATA: begin
          gmii_txd <= data_fifo_dout;
          crc_q <= crc_n;
          cnt <= (last_data && !pad_needed) ? '0 : cnt + 1'b1;
          state <= !last_data ? ST_DATA : (pad_needed ? ST_PAD : ST_FCS);
        end
        ST_PAD: begin
          gmii_txd <= 8'h00;
          crc_q <= crc_n;
          cnt <= cnt == MIN_L - 1'b1 ? '0 : cnt + 1'b1;
          state <= cnt == MIN_L - 1'b1 ? ST_FCS : ST_PAD;
        end
        ST_FCS: begin
          gmii_txd <= ~crc_q[{cnt[1:0], 3'b000} +: 8];
          cnt <= cnt[1:0] == 2'd3 ? '0 : cnt + 1'b1;
          state <= cnt[1:0] == 2'd3 ? ST_IFG : ST_FCS;
        end
        default: begin
          gmii_txd <= 8'h00;
          gmii_tx_en <= 1'b0;
          crc_q <= CRC_INIT;
          cnt <= cnt == LEN_W'(IFG_BYTES - 1) ? '0 : cnt + 1'b1;
          state <= cnt == LEN_W'(IFG_BYTES - 1) ? ST_IDLE : ST_IFG;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb_gmii_tx_framer: directed tests for the GMII transmit framer (default and unpadded instances).
module tb_gmii_tx_framer;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rstn = 1'b0;
  always #4 clk = ~clk;
  int nvec = 0, nerr = 0;

  logic a_prd, a_drd, a_en, a_er, a_busy, a_sent, a_lerr, a_pempty = 1'b1;
  logic [15:0] a_pdout = '0;
  logic [7:0] a_ddout = '0, a_txd;
  logic b_prd, b_drd, b_en, b_er, b_busy, b_sent, b_lerr, b_pempty = 1'b1;
  logic [15:0] b_pdout = '0;
  logic [7:0] b_ddout = '0, b_txd;

  gmii_tx_framer dut (.clk(clk), .rstn(rstn), .ptr_fifo_rd(a_prd), .ptr_fifo_dout(a_pdout),
    .ptr_fifo_empty(a_pempty), .data_fifo_rd(a_drd), .data_fifo_dout(a_ddout), .gmii_txd(a_txd),
    .gmii_tx_en(a_en), .gmii_tx_er(a_er), .tx_busy(a_busy), .frame_sent(a_sent), .len_err(a_lerr));
  gmii_tx_framer #(.MIN_FRAME(0)) dut0 (.clk(clk), .rstn(rstn), .ptr_fifo_rd(b_prd),
    .ptr_fifo_dout(b_pdout), .ptr_fifo_empty(b_pempty), .data_fifo_rd(b_drd),
    .data_fifo_dout(b_ddout), .gmii_txd(b_txd), .gmii_tx_en(b_en), .gmii_tx_er(b_er),
    .tx_busy(b_busy), .frame_sent(b_sent), .len_err(b_lerr));

  // standard-mode FIFO models, flushed by the shared reset
  logic [15:0] a_pq[$], b_pq[$];
  logic [7:0] a_dq[$], b_dq[$];
  always @(posedge clk) begin
    if (!rstn) begin
      a_pq.delete(); a_dq.delete(); b_pq.delete(); b_dq.delete();
      a_pempty <= 1'b1; b_pempty <= 1'b1;
    end else begin
      if (a_prd) a_pdout <= a_pq.pop_front();
      if (a_drd) a_ddout <= a_dq.pop_front();
      if (b_prd) b_pdout <= b_pq.pop_front();
      if (b_drd) b_ddout <= b_dq.pop_front();
      a_pempty <= a_pq.size() == 0;
      b_pempty <= b_pq.size() == 0;
    end
  end

  int a_cyc = 0, a_rd_cnt = 0, a_lerr_cnt = 0, a_done = 0, a_idle = 0, a_gap = 0, a_lat = 0;
  int a_rd_cyc = 0, a_rise_cyc = 0, a_lerr_cyc = 0, a_fs_in = 0, a_busy_bad = 0, b_done = 0;
  logic a_prev_en = 1'b0, a_prev_sent = 1'b0, a_fs_ok = 1'b0, b_prev_en = 1'b0;
  bq_t a_cur, a_last, b_cur, b_last;
  always @(negedge clk) begin
    a_cyc++;
    if (a_drd) a_rd_cnt++;
    if (a_lerr) begin a_lerr_cnt++; a_lerr_cyc = a_cyc; end
    if (a_prd) a_rd_cyc = a_cyc;
    if ((a_prd || a_en) && !a_busy) a_busy_bad++;
    if (a_en) begin
      if (!a_prev_en) begin
        a_gap = a_idle; a_lat = a_cyc - a_rd_cyc; a_rise_cyc = a_cyc; a_fs_in = 0; a_cur.delete();
      end
      a_cur.push_back(a_txd);
      if (a_sent) a_fs_in++;
      a_idle = 0;
    end else begin
      if (a_prev_en) begin a_fs_ok = a_prev_sent && a_fs_in == 1; a_last = a_cur; a_done++; end
      a_idle++;
    end
    a_prev_en = a_en; a_prev_sent = a_sent;
    if (b_en) begin
      if (!b_prev_en) b_cur.delete();
      b_cur.push_back(b_txd);
    end else if (b_prev_en) begin b_last = b_cur; b_done++; end
    b_prev_en = b_en;
  end

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] b);
    for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? (c >> 1) ^ 32'hEDB8_8320 : c >> 1;
    return c;
  endfunction

  task automatic build_frame(input bq_t d, input int minf, output bq_t f);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    f = {};
    repeat (7) f.push_back(8'h55);
    f.push_back(8'hD5);
    foreach (d[i]) begin f.push_back(d[i]); c = crc_ref(c, d[i]); end
    for (int i = d.size(); i < minf; i++) begin f.push_back(8'h00); c = crc_ref(c, 8'h00); end
    c = ~c;
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
  endtask

  function automatic int first_diff(input bq_t x, input bq_t y);
    int m;
    m = x.size() < y.size() ? x.size() : y.size();
    for (int i = 0; i < m; i++) if (x[i] !== y[i]) return i;
    return x.size() == y.size() ? -1 : m;
  endfunction

  task automatic push_a(input bq_t d);
    @(negedge clk);
    foreach (d[i]) a_dq.push_back(d[i]);
    a_pq.push_back(16'hA000 | 16'(d.size()));
  endtask

  task automatic wait_a(input int tgt);
    for (int i = 0; i < 9000 && a_done < tgt; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    nvec++; if ({a_txd, a_en, a_er, a_prd, a_drd, a_busy, a_sent, a_lerr} !== 15'd0) begin nerr++; $display("FAIL reset_a: outputs %h want 0", {a_txd, a_en, a_er, a_prd, a_drd, a_busy, a_sent, a_lerr}); end
    nvec++; if ({b_txd, b_en, b_er, b_prd, b_drd, b_busy, b_sent, b_lerr} !== 15'd0) begin nerr++; $display("FAIL reset_b: outputs %h want 0", {b_txd, b_en, b_er, b_prd, b_drd, b_busy, b_sent, b_lerr}); end
    rstn = 1'b1;
    begin
      int strobes;
      strobes = 0;
      repeat (10) begin @(negedge clk); if (a_prd || a_drd || a_en || a_busy) strobes++; end
      nvec++; if (strobes !== 0) begin nerr++; $display("FAIL idle_empty: %0d active cycles want 0", strobes); end
    end
  endtask

  task automatic test_n64;
    bq_t d, e;
    int d0, r0, l0;
    for (int i = 0; i < 64; i++) d.push_back(8'(i));
    build_frame(d, 60, e);
    d0 = a_done; r0 = a_rd_cnt; l0 = a_lerr_cnt;
    push_a(d);
    wait_a(d0 + 1);
    nvec++; if (a_done !== d0 + 1) begin nerr++; $display("FAIL n64_timeout: frames %0d want %0d", a_done - d0, 1); end
    nvec++; if (first_diff(a_last, e) !== -1) begin nerr++; $display("FAIL n64_frame: first diff at byte %0d", first_diff(a_last, e)); end
    nvec++; if (a_last.size() !== 76) begin nerr++; $display("FAIL n64_txen_len: %0d cycles want 76", a_last.size()); end
    nvec++; if (a_rd_cnt - r0 !== 64) begin nerr++; $display("FAIL n64_reads: %0d want 64", a_rd_cnt - r0); end
    nvec++; if (a_lat !== 2) begin nerr++; $display("FAIL n64_latency: %0d want 2", a_lat); end
    nvec++; if (a_fs_ok !== 1'b1) begin nerr++; $display("FAIL n64_frame_sent: %b want 1", a_fs_ok); end
    nvec++; if (a_lerr_cnt - l0 !== 0 || a_busy_bad !== 0) begin nerr++; $display("FAIL n64_flags: len_err %0d busy_bad %0d want 0 0", a_lerr_cnt - l0, a_busy_bad); end
  endtask

  task automatic test_crc_vector;
    int d0;
    d0 = b_done;
    @(negedge clk);
    for (int i = 0; i < 9; i++) b_dq.push_back(8'h31 + 8'(i));
    b_pq.push_back(16'd9);
    for (int i = 0; i < 2000 && b_done == d0; i++) @(negedge clk);
    nvec++; if (b_last.size() !== 21) begin nerr++; $display("FAIL crc_len: %0d want 21", b_last.size()); end
    nvec++; if ({b_last[17], b_last[18], b_last[19], b_last[20]} !== 32'h2639F4CB) begin nerr++; $display("FAIL crc_fcs: %h want 2639f4cb", {b_last[17], b_last[18], b_last[19], b_last[20]}); end
  endtask

  task automatic test_pad;
    bq_t d, e;
    int d0, r0, nz;
    logic [31:0] r, rr;
    for (int i = 0; i < 20; i++) d.push_back(8'hA0 + 8'(i));
    build_frame(d, 60, e);
    d0 = a_done; r0 = a_rd_cnt;
    push_a(d);
    wait_a(d0 + 1);
    nvec++; if (a_last.size() !== 72) begin nerr++; $display("FAIL pad_txen_len: %0d want 72", a_last.size()); end
    nz = 0;
    for (int i = 28; i < 68; i++) if (a_last[i] !== 8'h00) nz++;
    nvec++; if (nz !== 0) begin nerr++; $display("FAIL pad_zero: %0d nonzero pad bytes want 0", nz); end
    nvec++; if (a_rd_cnt - r0 !== 20) begin nerr++; $display("FAIL pad_reads: %0d want 20", a_rd_cnt - r0); end
    r = 32'hFFFF_FFFF;
    for (int i = 8; i < a_last.size(); i++) r = crc_ref(r, a_last[i]);
    rr = {<<{r}};
    nvec++; if (rr !== 32'hC704DD7B) begin nerr++; $display("FAIL pad_residue: %h want c704dd7b", rr); end
    nvec++; if (first_diff(a_last, e) !== -1) begin nerr++; $display("FAIL pad_frame: first diff at byte %0d", first_diff(a_last, e)); end
  endtask

  task automatic test_back_to_back;
    bq_t d1, d2, e1, e2;
    int d0;
    for (int i = 0; i < 60; i++) d1.push_back(8'(3 * i));
    for (int i = 0; i < 100; i++) d2.push_back(~8'(i));
    build_frame(d1, 60, e1);
    build_frame(d2, 60, e2);
    d0 = a_done;
    @(negedge clk);
    foreach (d1[i]) a_dq.push_back(d1[i]);
    foreach (d2[i]) a_dq.push_back(d2[i]);
    a_pq.push_back(16'd60);
    a_pq.push_back(16'h3000 | 16'd100);
    wait_a(d0 + 1);
    nvec++; if (first_diff(a_last, e1) !== -1) begin nerr++; $display("FAIL b2b_frame1: first diff at byte %0d", first_diff(a_last, e1)); end
    wait_a(d0 + 2);
    nvec++; if (a_done !== d0 + 2) begin nerr++; $display("FAIL b2b_timeout: frames %0d want 2", a_done - d0); end
    nvec++; if (first_diff(a_last, e2) !== -1) begin nerr++; $display("FAIL b2b_frame2: first diff at byte %0d", first_diff(a_last, e2)); end
    nvec++; if (a_gap < 13) begin nerr++; $display("FAIL b2b_gap: %0d idle cycles want >= 13", a_gap); end
    nvec++; if (a_fs_ok !== 1'b1) begin nerr++; $display("FAIL b2b_frame_sent: %b want 1", a_fs_ok); end
  endtask

  task automatic test_len_zero;
    bq_t d, e;
    int d0, r0, l0;
    for (int i = 0; i < 60; i++) d.push_back(8'h5A ^ 8'(i));
    build_frame(d, 60, e);
    d0 = a_done; r0 = a_rd_cnt; l0 = a_lerr_cnt;
    @(negedge clk);
    a_pq.push_back(16'h5000);
    foreach (d[i]) a_dq.push_back(d[i]);
    a_pq.push_back(16'd60);
    wait_a(d0 + 1);
    repeat (20) @(negedge clk);
    nvec++; if (a_lerr_cnt - l0 !== 1) begin nerr++; $display("FAIL lz_len_err: %0d pulses want 1", a_lerr_cnt - l0); end
    nvec++; if (a_rd_cnt - r0 !== 60) begin nerr++; $display("FAIL lz_reads: %0d want 60", a_rd_cnt - r0); end
    nvec++; if (a_done - d0 !== 1) begin nerr++; $display("FAIL lz_frames: %0d want 1", a_done - d0); end
    nvec++; if (first_diff(a_last, e) !== -1) begin nerr++; $display("FAIL lz_frame: first diff at byte %0d", first_diff(a_last, e)); end
    nvec++; if (a_rise_cyc - a_lerr_cyc < 13) begin nerr++; $display("FAIL lz_gap: %0d cycles want >= 13", a_rise_cyc - a_lerr_cyc); end
  endtask

  task automatic test_jumbo;
    bq_t d, e;
    int d0, r0;
    for (int i = 0; i < 4095; i++) d.push_back(8'(i * 7 + 1));
    build_frame(d, 60, e);
    d0 = a_done; r0 = a_rd_cnt;
    push_a(d);
    wait_a(d0 + 1);
    nvec++; if (a_last.size() !== 4107) begin nerr++; $display("FAIL jumbo_len: %0d want 4107", a_last.size()); end
    nvec++; if (a_rd_cnt - r0 !== 4095) begin nerr++; $display("FAIL jumbo_reads: %0d want 4095", a_rd_cnt - r0); end
    nvec++; if (first_diff(a_last, e) !== -1) begin nerr++; $display("FAIL jumbo_frame: first diff at byte %0d", first_diff(a_last, e)); end
  endtask

  task automatic test_reset_mid;
    bq_t d, e;
    int d0, r0;
    for (int i = 0; i < 1500; i++) d.push_back(8'(i));
    r0 = a_rd_cnt;
    push_a(d);
    for (int i = 0; i < 4000 && a_rd_cnt - r0 < 300; i++) @(negedge clk);
    nvec++; if (a_en !== 1'b1) begin nerr++; $display("FAIL rst_mid_active: tx_en %b want 1", a_en); end
    #2 rstn = 1'b0;
    #1;
    nvec++; if (a_en !== 1'b0) begin nerr++; $display("FAIL rst_async_txen: %b want 0", a_en); end
    repeat (3) @(negedge clk);
    nvec++; if ({a_txd, a_en, a_er, a_prd, a_drd, a_busy, a_sent, a_lerr} !== 15'd0) begin nerr++; $display("FAIL rst_outputs: %h want 0", {a_txd, a_en, a_er, a_prd, a_drd, a_busy, a_sent, a_lerr}); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    d = {};
    for (int i = 0; i < 64; i++) d.push_back(8'hC0 ^ 8'(i));
    build_frame(d, 60, e);
    d0 = a_done;
    push_a(d);
    wait_a(d0 + 1);
    nvec++; if (first_diff(a_last, e) !== -1) begin nerr++; $display("FAIL rst_recover_frame: first diff at byte %0d", first_diff(a_last, e)); end
    nvec++; if (a_fs_ok !== 1'b1) begin nerr++; $display("FAIL rst_recover_sent: %b want 1", a_fs_ok); end
  endtask

  initial begin
    test_reset;
    test_n64;
    test_crc_vector;
    test_pad;
    test_back_to_back;
    test_len_zero;
    test_jumbo;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
